// File: rtl/shift_issue_stage_pkg.sv
// ----------------------------------------------------------------------------
// shift_issue_stage_pkg
// Shared definitions for the SimpleALU shift unit:
//   - default operand and shift-amount widths
//   - shift opcode encoding (matches the 2-bit in_op field)
// No ports; imported by shift_core and shift_issue_stage.
// ----------------------------------------------------------------------------
package shift_issue_stage_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int SHAMT_W_DEF = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } shift_op_e;

endpackage

// File: rtl/shift_issue_stage_core.sv
// ----------------------------------------------------------------------------
// left_shifter / right_shifter / shift_core
// Combinational shift datapath.
//   left_shifter  : i_data, i_shamt -> o_data = i_data << i_shamt (zero fill)
//   right_shifter : i_data, i_shamt -> o_data = i_data >> i_shamt (zero fill)
//   shift_core    : i_data  [DATA_W]   operand
//                   i_shamt [SHAMT_W]  shift amount
//                   i_op    shift_op_e SLL / SRL / SRA / ROTR
//                   o_result[DATA_W]   shifted value
// ----------------------------------------------------------------------------
module left_shifter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [DATA_W-1:0]  o_data
);
  assign o_data = i_data << i_shamt;
endmodule

module right_shifter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [DATA_W-1:0]  o_data
);
  assign o_data = i_data >> i_shamt;
endmodule

module shift_core
  import shift_issue_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  shift_op_e          i_op,
  output logic [DATA_W-1:0]  o_result
);

  logic [DATA_W-1:0]  w_left;
  logic [DATA_W-1:0]  w_right;
  logic [DATA_W-1:0]  w_rot_left;
  logic [DATA_W-1:0]  w_fill_mask;
  logic [SHAMT_W-1:0] w_rot_amt;
  logic [DATA_W-1:0]  w_sra;
  logic [DATA_W-1:0]  w_rotr;
  logic               w_sign;

  // Rotate-right by s is (d >> s) | (d << (DATA_W - s)). Taking DATA_W - s
  // modulo DATA_W (a two's-complement negate in SHAMT_W bits) folds s = 0
  // onto a zero left shift, so no full-width shift is ever formed and
  // d | d returns d unchanged.
  assign w_rot_amt = '0 - i_shamt;
  assign w_sign    = i_data[DATA_W-1];

  left_shifter #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_sll (
    .i_data  (i_data),
    .i_shamt (i_shamt),
    .o_data  (w_left)
  );

  right_shifter #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_srl (
    .i_data  (i_data),
    .i_shamt (i_shamt),
    .o_data  (w_right)
  );

  left_shifter #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_rotl (
    .i_data  (i_data),
    .i_shamt (w_rot_amt),
    .o_data  (w_rot_left)
  );

  // All-ones shifted right marks the bits the logical shift kept; its
  // complement is exactly the vacated upper field that SRA sign-fills.
  right_shifter #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_mask (
    .i_data  ({DATA_W{1'b1}}),
    .i_shamt (i_shamt),
    .o_data  (w_fill_mask)
  );

  assign w_sra  = w_right | (w_sign ? ~w_fill_mask : '0);
  assign w_rotr = w_right | w_rot_left;

  always_comb begin
    o_result = w_left;
    unique case (i_op)
      OP_SLL:  o_result = w_left;
      OP_SRL:  o_result = w_right;
      OP_SRA:  o_result = w_sra;
      OP_ROTR: o_result = w_rotr;
      default: o_result = w_left;
    endcase
  end

endmodule

// File: rtl/shift_issue_stage.sv
// ----------------------------------------------------------------------------
// shift_issue_stage
// Two-stage valid/ready pipelined shift unit for the SimpleALU writeback mux.
// Stage 1 registers the operand/shamt/opcode; stage 2 registers the shifted
// result and its zero flag. A consumer stall holds both stages in place.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     upstream handshake
//   in_data, in_shamt       operand and shift amount (0..DATA_W-1)
//   in_op                   00 SLL, 01 SRL, 10 SRA, 11 ROTR
//   out_valid / out_ready   downstream handshake
//   out_result, out_zero    shifted value and (out_result == 0)
// ----------------------------------------------------------------------------
module shift_issue_stage
  import shift_issue_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic               out_zero
);

  logic               r_vld_p1;
  logic [DATA_W-1:0]  r_data_p1;
  logic [SHAMT_W-1:0] r_shamt_p1;
  shift_op_e          r_op_p1;

  logic               r_vld_p2;
  logic [DATA_W-1:0]  r_result_p2;
  logic               r_zero_p2;

  logic               w_s2_adv;
  logic               w_in_xfer;
  logic [DATA_W-1:0]  w_result;

  // Ready is combinational from out_ready: a draining S2 frees S1 in the
  // same cycle, which is what sustains one op per cycle without a skid.
  assign w_s2_adv  = !r_vld_p2 || out_ready;
  assign in_ready  = !r_vld_p1 || w_s2_adv;
  assign w_in_xfer = in_valid && in_ready;

  // ---- stage 1: operand / shamt / opcode capture ----
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_p1   <= 1'b0;
      r_data_p1  <= '0;
      r_shamt_p1 <= '0;
      r_op_p1    <= OP_SLL;
    end else if (w_in_xfer) begin
      r_vld_p1   <= 1'b1;
      r_data_p1  <= in_data;
      r_shamt_p1 <= in_shamt;
      r_op_p1    <= shift_op_e'(in_op);
    end else if (w_s2_adv) begin
      r_vld_p1   <= 1'b0;
    end
  end

  shift_core #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_core (
    .i_data   (r_data_p1),
    .i_shamt  (r_shamt_p1),
    .i_op     (r_op_p1),
    .o_result (w_result)
  );

  // ---- stage 2: result register feeding writeback ----
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_p2    <= 1'b0;
      r_result_p2 <= '0;
      r_zero_p2   <= 1'b1;
    end else if (w_s2_adv) begin
      r_vld_p2    <= r_vld_p1;
      r_result_p2 <= w_result;
      r_zero_p2   <= (w_result == '0);
    end
  end

  assign out_valid  = r_vld_p2;
  assign out_result = r_result_p2;
  assign out_zero   = r_zero_p2;

endmodule

// File: tb/tb_shift_issue_stage.sv
module tb_shift_issue_stage;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  shift_issue_stage #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_shamt   (in_shamt),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Independent reference: native signed shift and a doubled-word rotate.
  function automatic logic [31:0] ref_shift(input logic [31:0] d,
                                            input logic [4:0] s,
                                            input logic [1:0] op);
    logic [63:0] dd;
    case (op)
      2'b00:   ref_shift = d << s;
      2'b01:   ref_shift = d >> s;
      2'b10:   ref_shift = $unsigned($signed(d) >>> s);
      default: begin
        dd = {d, d} >> s;
        ref_shift = dd[31:0];
      end
    endcase
  endfunction

  // One clock cycle: sample at the falling edge, return just after the rise.
  task automatic cyc(output logic acc, output logic ov,
                     output logic [31:0] res, output logic z);
    @(negedge clock);
    acc = in_valid && in_ready;
    ov  = out_valid;
    res = out_result;
    z   = out_zero;
    @(posedge clock);
    #1;
  endtask

  // Issue one op into an idle pipe with out_ready high; report result and
  // the number of cycles from the accept cycle to out_valid (-1 on timeout).
  task automatic issue_and_wait(input logic [31:0] d, input logic [4:0] s,
                                input logic [1:0] op, output logic [31:0] res,
                                output logic z, output int lat);
    logic acc, ov;
    logic [31:0] r;
    logic zz;
    bit done;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = d; in_shamt = s; in_op = op;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) cyc(acc, ov, r, zz);
    in_valid = 1'b0;
    lat = -1; res = 'x; z = 1'bx;
    done = 1'b0;
    if (acc) begin
      for (int i = 1; i <= 10 && !done; i++) begin
        cyc(acc, ov, r, zz);
        if (ov) begin lat = i; res = r; z = zz; done = 1'b1; end
      end
    end
  endtask

  task automatic test_reset();
    logic acc, ov, z;
    logic [31:0] res;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_shamt = '0; in_op = '0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    @(posedge clock); #1;
    cyc(acc, ov, res, z);
    checks++;
    if (ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov); end
    checks++;
    if (res !== 32'h0) begin errors++; $display("FAIL reset_out_result got %h want 0", res); end
    checks++;
    if (z !== 1'b1) begin errors++; $display("FAIL reset_out_zero got %b want 1", z); end
  endtask

  task automatic test_sll();
    logic [31:0] res; logic z; int lat;
    issue_and_wait(32'h0000_0001, 5'd31, 2'b00, res, z, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL sll_latency got %0d want 2", lat); end
    checks++;
    if (res !== 32'h8000_0000) begin errors++; $display("FAIL sll_result got %h want 80000000", res); end
    checks++;
    if (z !== 1'b0) begin errors++; $display("FAIL sll_zero got %b want 0", z); end
  endtask

  task automatic test_sra_srl();
    logic [31:0] res; logic z; int lat;
    issue_and_wait(32'h8000_00F0, 5'd4, 2'b10, res, z, lat);
    checks++;
    if (res !== 32'hF800_000F) begin errors++; $display("FAIL sra_neg got %h want f800000f", res); end
    issue_and_wait(32'h8000_00F0, 5'd4, 2'b01, res, z, lat);
    checks++;
    if (res !== 32'h0800_000F) begin errors++; $display("FAIL srl got %h want 0800000f", res); end
    issue_and_wait(32'h7FFF_FFFF, 5'd31, 2'b10, res, z, lat);
    checks++;
    if (res !== 32'h0) begin errors++; $display("FAIL sra_pos got %h want 0", res); end
    checks++;
    if (z !== 1'b1) begin errors++; $display("FAIL sra_pos_zero got %b want 1", z); end
  endtask

  task automatic test_rotr_zero_shift();
    logic [31:0] res; logic z; int lat;
    issue_and_wait(32'h1234_5678, 5'd8, 2'b11, res, z, lat);
    checks++;
    if (res !== 32'h7812_3456) begin errors++; $display("FAIL rotr8 got %h want 78123456", res); end
    for (int op = 0; op < 4; op++) begin
      issue_and_wait(32'h1234_5678, 5'd0, op[1:0], res, z, lat);
      checks++;
      if (res !== 32'h1234_5678) begin
        errors++; $display("FAIL shamt0_op%0d got %h want 12345678", op, res);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [4];
    logic [4:0]  s [4];
    logic [1:0]  o [4];
    logic [31:0] e [4];
    logic acc, ov, z;
    logic [31:0] res;
    d = '{32'h0000_000F, 32'hF000_0000, 32'h8000_0000, 32'h0000_0001};
    s = '{5'd4, 5'd28, 5'd31, 5'd1};
    o = '{2'b00, 2'b01, 2'b10, 2'b11};
    e = '{32'h0000_00F0, 32'h0000_000F, 32'hFFFF_FFFF, 32'h8000_0000};
    out_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      if (t < 4) begin
        in_valid = 1'b1; in_data = d[t]; in_shamt = s[t]; in_op = o[t];
      end else begin
        in_valid = 1'b0;
      end
      cyc(acc, ov, res, z);
      if (t < 4) begin
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL b2b_accept%0d got %b want 1", t, acc); end
      end
      checks++;
      if (ov !== (t >= 2 && t <= 5)) begin
        errors++; $display("FAIL b2b_valid_t%0d got %b want %b", t, ov, (t >= 2 && t <= 5));
      end
      if (t >= 2 && t <= 5) begin
        checks++;
        if (res !== e[t-2]) begin
          errors++; $display("FAIL b2b_result%0d got %h want %h", t - 2, res, e[t-2]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic acc, ov, z;
    logic [31:0] res;
    logic [31:0] exp [3];
    int n;
    bit c_taken;
    exp = '{32'h0000_0006, 32'h0000_0001, 32'hFF00_0000};
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h3; in_shamt = 5'd1; in_op = 2'b00;
    cyc(acc, ov, res, z);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL stall_accA got %b want 1", acc); end
    in_data = 32'h100; in_shamt = 5'd8; in_op = 2'b01;
    cyc(acc, ov, res, z);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL stall_accB got %b want 1", acc); end
    // Junk held on the inputs while full must not be captured.
    in_data = 32'hDEAD_BEEF; in_shamt = 5'd3; in_op = 2'b10;
    for (int k = 0; k < 3; k++) begin
      cyc(acc, ov, res, z);
      checks++;
      if (acc !== 1'b0) begin errors++; $display("FAIL stall_ready%0d got %b want 0", k, acc); end
      checks++;
      if (ov !== 1'b1 || res !== 32'h6) begin
        errors++; $display("FAIL stall_hold%0d got v=%b r=%h want v=1 r=00000006", k, ov, res);
      end
    end
    in_data = 32'hF000_000F; in_shamt = 5'd4; in_op = 2'b11;
    out_ready = 1'b1;
    n = 0; c_taken = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(acc, ov, res, z);
      if (acc) begin c_taken = 1'b1; in_valid = 1'b0; end
      if (ov) begin
        checks++;
        if (n >= 3) begin
          errors++; $display("FAIL stall_extra got %h want none", res);
        end else if (res !== exp[n]) begin
          errors++; $display("FAIL stall_drain%0d got %h want %h", n, res, exp[n]);
        end
        n++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (!c_taken || n != 3) begin
      errors++; $display("FAIL stall_count got acc=%0d n=%0d want acc=1 n=3", c_taken, n);
    end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [31:0] expq[$];
    logic acc, ov, z, cur_ordy, prev_ov, prev_ordy;
    logic [31:0] res, prev_res, e;
    int sent, recv, ncyc;
    sent = 0; recv = 0; ncyc = 0;
    prev_ov = 1'b0; prev_ordy = 1'b1; prev_res = '0;
    in_valid = 1'b0;
    while (recv < N && ncyc < 60000) begin
      if (!in_valid && sent < N && $urandom_range(0, 9) < 7) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        in_shamt = 5'($urandom_range(0, 31));
        in_op    = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      if (sent >= N) out_ready = 1'b1;
      cur_ordy = out_ready;
      cyc(acc, ov, res, z);
      if (acc) begin
        expq.push_back(ref_shift(in_data, in_shamt, in_op));
        sent++;
        in_valid = 1'b0;
      end
      if (prev_ov && !prev_ordy) begin
        checks++;
        if (ov !== 1'b1 || res !== prev_res) begin
          errors++; $display("FAIL rand_stable got v=%b r=%h want v=1 r=%h", ov, res, prev_res);
        end
      end
      if (ov && cur_ordy) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rand_spurious got %h want none", res);
        end else begin
          e = expq.pop_front();
          if (res !== e || z !== (e == 32'h0)) begin
            errors++; $display("FAIL rand_result%0d got %h z=%b want %h z=%b", recv, res, z, e, (e == 32'h0));
          end
        end
        recv++;
      end
      prev_ov = ov; prev_ordy = cur_ordy; prev_res = res;
      ncyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv != N || expq.size() != 0) begin
      errors++; $display("FAIL rand_count got %0d pending %0d want %0d pending 0", recv, expq.size(), N);
    end
  endtask

  task automatic test_mid_reset();
    logic acc, ov, z;
    logic [31:0] res;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hFFFF_0000; in_shamt = 5'd4; in_op = 2'b00;
    cyc(acc, ov, res, z);
    in_data = 32'h0000_FFFF; in_shamt = 5'd2; in_op = 2'b01;
    cyc(acc, ov, res, z);
    in_valid = 1'b0;
    cyc(acc, ov, res, z);
    checks++;
    if (ov !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mreset_full got v=%b rdy=%b want v=1 rdy=0", ov, in_ready);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    cyc(acc, ov, res, z);
    checks++;
    if (ov !== 1'b0 || res !== 32'h0) begin
      errors++; $display("FAIL mreset_out got v=%b r=%h want v=0 r=00000000", ov, res);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL mreset_stale%0d got v=%b rdy=%b want v=0 rdy=1", k, out_valid, in_ready);
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_sra_srl();
    test_rotr_zero_shift();
    test_back_to_back();
    test_stall();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
